hazard_scoreboard: RTL

- Parametrised successor to the decode-stage stall unit.
- Replaces per-instruction combinational Tnew bookkeeping with a registered scoreboard of in-flight register writes, one entry per post-decode stage.
- Adds an internal multiply/divide busy counter and forwarding-source selects.
- Sits beside the D stage. Consumes pre-decoded D-stage operand and Tuse/Tnew info; drives pipeline enables, the D/E bubble, MD start/busy and forward-mux selects.

---
 rtl/hazard_scoreboard.sv | 127 ++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: scoreboard of in-flight register writes, one entry
// per post-decode stage, plus a multiply/divide busy tracker and forward selects.
module hazard_scoreboard #(
    parameter int unsigned NSTAGE   = 3,
    parameter int unsigned AW       = 5,
    parameter int unsigned TW       = 2,
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter int unsigned SW       = $clog2(NSTAGE + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] d_rs,
    input  logic [AW-1:0] d_rt,
    input  logic          d_rs_used,
    input  logic          d_rt_used,
    input  logic [TW-1:0] d_tuse_rs,
    input  logic [TW-1:0] d_tuse_rt,
    input  logic [AW-1:0] d_wa,
    input  logic [TW-1:0] d_tnew,
    input  logic          d_md_op,
    input  logic          d_md_div,
    input  logic          d_md_acc,
    output logic          stall,
    output logic          en_pc,
    output logic          en_fd,
    output logic          clr_de,
    output logic          md_start,
    output logic          md_busy,
    output logic [SW-1:0] fwd_rs_sel,
    output logic [SW-1:0] fwd_rt_sel
);

    localparam int unsigned MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int unsigned CW      = $clog2(MAX_LAT + 1);

    logic [AW-1:0] wa_q   [1:NSTAGE];
    logic [AW-1:0] wa_d   [1:NSTAGE];
    logic [TW-1:0] tnew_q [1:NSTAGE];
    logic [TW-1:0] tnew_d [1:NSTAGE];
    logic          e_md_q, e_md_d;
    logic          e_div_q, e_div_d;
    logic [CW-1:0] md_cnt_q, md_cnt_d;

    logic          rs_hit, rt_hit;
    logic [TW-1:0] rs_tnew, rt_tnew;
    logic [SW-1:0] rs_k, rt_k;
    logic          stall_rs, stall_rt, stall_md;

    // Youngest-match search: scanning oldest to youngest lets the lowest k win.
    always_comb begin
        rs_hit  = 1'b0;
        rs_tnew = '0;
        rs_k    = '0;
        rt_hit  = 1'b0;
        rt_tnew = '0;
        rt_k    = '0;
        for (int k = int'(NSTAGE); k >= 1; k--) begin
            if (d_rs_used && (d_rs != '0) && (wa_q[k] == d_rs)) begin
                rs_hit  = 1'b1;
                rs_tnew = tnew_q[k];
                rs_k    = SW'(k);
            end
            if (d_rt_used && (d_rt != '0) && (wa_q[k] == d_rt)) begin
                rt_hit  = 1'b1;
                rt_tnew = tnew_q[k];
                rt_k    = SW'(k);
            end
        end
    end

    // Stall and forward decisions; the producer is forwardable once its tnew is 0.
    always_comb begin
        stall_rs   = rs_hit && (rs_tnew > d_tuse_rs);
        stall_rt   = rt_hit && (rt_tnew > d_tuse_rt);
        stall_md   = (d_md_acc | d_md_op) & (e_md_q | md_busy);
        stall      = stall_rs | stall_rt | stall_md;
        en_pc      = ~stall;
        en_fd      = ~stall;
        clr_de     = stall;
        md_start   = e_md_q;
        md_busy    = (md_cnt_q != '0);
        fwd_rs_sel = (rs_hit && (rs_tnew == '0)) ? rs_k : '0;
        fwd_rt_sel = (rt_hit && (rt_tnew == '0)) ? rt_k : '0;
    end

    // Next state: scoreboard shift with saturating tnew age, MD flags and counter.
    always_comb begin
        wa_d[1]   = stall ? '0 : d_wa;
        tnew_d[1] = stall ? '0 : d_tnew;
        for (int k = 2; k <= int'(NSTAGE); k++) begin
            wa_d[k]   = wa_q[k-1];
            tnew_d[k] = (tnew_q[k-1] != '0) ? (tnew_q[k-1] - TW'(1)) : '0;
        end
        e_md_d  = ~stall & d_md_op;
        e_div_d = ~stall & d_md_op & d_md_div;
        if (e_md_q) begin
            md_cnt_d = e_div_q ? CW'(DIV_LAT) : CW'(MULT_LAT);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CW'(1);
        end else begin
            md_cnt_d = '0;
        end
    end

    // State registers; reset clears everything without waiting for a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 1; k <= int'(NSTAGE); k++) begin
                wa_q[k]   <= '0;
                tnew_q[k] <= '0;
            end
            e_md_q   <= 1'b0;
            e_div_q  <= 1'b0;
            md_cnt_q <= '0;
        end else begin
            for (int k = 1; k <= int'(NSTAGE); k++) begin
                wa_q[k]   <= wa_d[k];
                tnew_q[k] <= tnew_d[k];
            end
            e_md_q   <= e_md_d;
            e_div_q  <= e_div_d;
            md_cnt_q <= md_cnt_d;
        end
    end

endmodule
